// File: rtl/data_mem_responder.sv
// Load/store data memory: one request at a time, response LATENCY edges after accept.
// Request side stalls (reqReady=0) until the response handshakes; the response is held while respReady=0.
module data_mem_responder #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 1024,
   parameter int LATENCY    = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  reqValid,
   output logic                  reqReady,
   input  logic                  reqWrite,
   input  logic [2:0]            reqFunc3,
   input  logic [DATA_WIDTH-1:0] reqAddr,
   input  logic [DATA_WIDTH-1:0] reqWData,
   output logic                  respValid,
   input  logic                  respReady,
   output logic [DATA_WIDTH-1:0] respRData,
   output logic                  respErr
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } state_t;

   state_t                  state;
   logic [3:0]              count;
   logic                    capWrite;
   logic [2:0]              capFunc3;
   logic [DATA_WIDTH-1:0]   capAddr;
   logic [DATA_WIDTH-1:0]   capWData;
   logic                    reqReadyQ;
   logic                    respValidQ;
   logic [DATA_WIDTH-1:0]   respRDataQ;
   logic                    respErrQ;

   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   logic [DATA_WIDTH-3:0]   wordIdx;
   logic [IDX_W-1:0]        memIdx;
   logic [DATA_WIDTH-1:0]   curWord;
   logic                    outOfRange;
   logic                    misaligned;
   logic                    illegalOp;
   logic                    accErr;
   logic [4:0]              byteShift;
   logic [7:0]              byteSel;
   logic [15:0]             halfSel;
   logic [DATA_WIDTH-1:0]   loadData;
   logic [DATA_WIDTH-1:0]   storeMask;
   logic [DATA_WIDTH-1:0]   storeData;
   logic [DATA_WIDTH-1:0]   newWord;
   logic                    lastBusy;
   logic                    commit;

   assign reqReady  = reqReadyQ;
   assign respValid = respValidQ;
   assign respRData = respRDataQ;
   assign respErr   = respErrQ;

   // Access evaluation runs off the captured request; only sampled in BUSY's final cycle.
   always_comb begin
      wordIdx    = capAddr[DATA_WIDTH-1:2];
      memIdx     = capAddr[IDX_W+1:2];
      outOfRange = ({2'b00, wordIdx} >= DATA_WIDTH'(DEPTH));
      curWord    = mem[memIdx];
      byteShift  = {capAddr[1:0], 3'b000};
      byteSel    = 8'(curWord >> byteShift);
      halfSel    = capAddr[1] ? curWord[31:16] : curWord[15:0];

      misaligned = 1'b0;
      case (capFunc3[1:0])
         2'd1:    misaligned = capAddr[0];
         2'd2:    misaligned = (capAddr[1:0] != 2'b00);
         default: misaligned = 1'b0;
      endcase

      if (capWrite) begin
         illegalOp = (capFunc3 >= 3'd3);
      end else begin
         illegalOp = (capFunc3 == 3'd3) || (capFunc3 == 3'd6) || (capFunc3 == 3'd7);
      end

      accErr = outOfRange || misaligned || illegalOp;

      loadData = '0;
      case (capFunc3)
         3'd0:    loadData = {{24{byteSel[7]}}, byteSel};
         3'd1:    loadData = {{16{halfSel[15]}}, halfSel};
         3'd2:    loadData = curWord;
         3'd4:    loadData = {24'b0, byteSel};
         3'd5:    loadData = {16'b0, halfSel};
         default: loadData = '0;
      endcase

      storeMask = '1;
      storeData = capWData;
      case (capFunc3)
         3'd0: begin
            storeMask = 32'h0000_00FF << byteShift;
            storeData = {4{capWData[7:0]}};
         end
         3'd1: begin
            storeMask = 32'h0000_FFFF << {capAddr[1], 4'b0000};
            storeData = {2{capWData[15:0]}};
         end
         default: begin
            storeMask = '1;
            storeData = capWData;
         end
      endcase

      newWord  = (curWord & ~storeMask) | (storeData & storeMask);
      lastBusy = (state == BUSY) && (count == 4'd0);
      commit   = lastBusy && capWrite && !accErr;
   end

   // Array has no reset; a reset forces IDLE so an in-flight store can never commit.
   always_ff @(posedge clk) begin
      if (commit) begin
         mem[memIdx] <= newWord;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         count      <= 4'd0;
         capWrite   <= 1'b0;
         capFunc3   <= 3'd0;
         capAddr    <= '0;
         capWData   <= '0;
         reqReadyQ  <= 1'b1;
         respValidQ <= 1'b0;
         respRDataQ <= '0;
         respErrQ   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (reqValid && reqReadyQ) begin
                  capWrite  <= reqWrite;
                  capFunc3  <= reqFunc3;
                  capAddr   <= reqAddr;
                  capWData  <= reqWData;
                  count     <= 4'(LATENCY - 1);
                  reqReadyQ <= 1'b0;
                  state     <= BUSY;
               end
            end
            BUSY: begin
               if (count != 4'd0) begin
                  count <= count - 4'd1;
               end else begin
                  respErrQ   <= accErr;
                  respRDataQ <= (accErr || capWrite) ? '0 : loadData;
                  respValidQ <= 1'b1;
                  state      <= RESP;
               end
            end
            RESP: begin
               // No request accept in the handshake cycle; reqReady returns on the next one.
               if (respReady) begin
                  respValidQ <= 1'b0;
                  respRDataQ <= '0;
                  respErrQ   <= 1'b0;
                  reqReadyQ  <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
